// File: rtl/usb_rx_decoder.sv
// USB full-speed receive front end: line sync, bit recovery, NRZI decode,
// bit unstuffing, SYNC check, LSB-first byte assembly, EOP and error flags.
// Ports: clk/rst (async, active-high); rx_d_plus/rx_d_minus raw line inputs;
//        rx_data + data_valid byte output; rx_active packet window;
//        eop_strobe / rx_error single-cycle status strobes.
// Latency: data_valid and eop_strobe assert the cycle after the deciding sample.
// Backpressure: none; the line cannot be stalled, so every output is a strobe.
`timescale 1ns/1ps
module usb_rx_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_d_plus,
  input  logic       rx_d_minus,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       rx_active,
  output logic       eop_strobe,
  output logic       rx_error
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, SYNC, RECV, EOPW, ERRW} state_t;

  state_t        state;
  logic          dp_s1, dp_s2, dm_s1, dm_s2;
  logic          dp_d;
  logic [TW-1:0] timer;
  logic          prev_bit;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [2:0]    ones_cnt;
  logic          se0_seen;

  logic       line_j, line_k, line_se0, line_jk;
  logic       dp_edge, sample, nrzi_bit;
  logic [7:0] shift_next;

  always_comb begin
    line_j     = dp_s2 & ~dm_s2;
    line_k     = ~dp_s2 & dm_s2;
    line_se0   = ~dp_s2 & ~dm_s2;
    line_jk    = line_j | line_k;
    dp_edge    = dp_s2 ^ dp_d;
    sample     = (timer == TW'(SAMPLE_POINT));
    nrzi_bit   = (dp_s2 == prev_bit);
    shift_next = {nrzi_bit, shift[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1      <= 1'b1;
      dp_s2      <= 1'b1;
      dm_s1      <= 1'b0;
      dm_s2      <= 1'b0;
      dp_d       <= 1'b1;
      timer      <= '0;
      prev_bit   <= 1'b1;
      shift      <= '0;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      se0_seen   <= 1'b0;
      state      <= IDLE;
      rx_data    <= '0;
      data_valid <= 1'b0;
      rx_active  <= 1'b0;
      eop_strobe <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      eop_strobe <= 1'b0;
      rx_error   <= 1'b0;

      dp_s1 <= rx_d_plus;
      dp_s2 <= dp_s1;
      dm_s1 <= rx_d_minus;
      dm_s2 <= dm_s1;
      dp_d  <= dp_s2;

      // Resync on D+ transitions; SE0 entry/exit edges are not data edges
      // except the SE0->J rise, which is seen here as a J-state edge.
      if (dp_edge && !line_se0)
        timer <= '0;
      else if (timer == TW'(CLKS_PER_BIT - 1))
        timer <= '0;
      else
        timer <= timer + TW'(1);

      case (state)
        IDLE: begin
          // Idle line is J; pin the NRZI reference so the first SYNC K decodes as 0
          // even if a sample lands on the very edge cycle.
          prev_bit <= 1'b1;
          if (dp_edge && line_k) begin
            state   <= SYNC;
            shift   <= '0;
            bit_cnt <= '0;
          end
        end

        SYNC: begin
          if (sample) begin
            if (line_jk) begin
              prev_bit <= dp_s2;
              shift    <= shift_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift_next == 8'h80) begin
                  state     <= RECV;
                  rx_active <= 1'b1;
                  ones_cnt  <= 3'd1;  // SYNC's trailing 1 counts toward stuffing
                end else begin
                  rx_error <= 1'b1;
                  se0_seen <= 1'b0;
                  state    <= ERRW;
                end
              end
            end else begin
              rx_error <= 1'b1;
              se0_seen <= line_se0;
              state    <= ERRW;
            end
          end
        end

        RECV: begin
          if (sample) begin
            if (line_jk) begin
              prev_bit <= dp_s2;
              if (ones_cnt == 3'd6) begin
                if (nrzi_bit) begin
                  rx_error  <= 1'b1;
                  rx_active <= 1'b0;
                  se0_seen  <= 1'b0;
                  state     <= ERRW;
                end else begin
                  ones_cnt <= '0;
                end
              end else begin
                shift    <= shift_next;
                bit_cnt  <= bit_cnt + 3'd1;
                ones_cnt <= nrzi_bit ? ones_cnt + 3'd1 : 3'd0;
                if (bit_cnt == 3'd7) begin
                  rx_data    <= shift_next;
                  data_valid <= 1'b1;
                end
              end
            end else if (line_se0 && bit_cnt == 3'd0) begin
              state <= EOPW;
            end else begin
              // SE0 mid-byte or SE1
              rx_error  <= 1'b1;
              rx_active <= 1'b0;
              se0_seen  <= line_se0;
              state     <= ERRW;
            end
          end
        end

        EOPW: begin
          if (sample) begin
            if (line_j) begin
              prev_bit   <= 1'b1;
              eop_strobe <= 1'b1;
              rx_active  <= 1'b0;
              state      <= IDLE;
            end else if (!line_se0) begin
              rx_error  <= 1'b1;
              rx_active <= 1'b0;
              se0_seen  <= 1'b0;
              state     <= ERRW;
            end
          end
        end

        ERRW: begin
          rx_active <= 1'b0;
          if (sample) begin
            if (line_jk)
              prev_bit <= dp_s2;
            if (line_se0)
              se0_seen <= 1'b1;
            else if (line_j && se0_seen)
              state <= IDLE;
            else
              se0_seen <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
